// File: rtl/spine_port_injector.sv
// rtl/spine_port_injector.sv - queues local requests and paces 16-bit spine packets into one router input port
// Header dest sits in the top six bits; a reload cycle plus the gap count match the router's capture cadence.
module spine_port_injector #(
    parameter int          DWIDTH     = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter int          GAP_CYCLES = 4,
    parameter logic [5:0]  LOCAL_ADDR = 6'b000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [5:0]        req_dest,
    input  logic [DWIDTH-7:0] req_payload,
    output logic              req_ready,
    output logic              req_err,
    output logic [DWIDTH-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_full,
    output logic [15:0]       sent_count,
    output logic              busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    state_t            state_q, state_d;
    logic [DWIDTH-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              req_err_q, req_err_d;
    logic [15:0]       sent_count_q, sent_count_d;
    logic [3:0]        gap_q, gap_d;

    logic fifo_full;
    logic req_hit;
    logic push;
    logic pop;

    always_comb begin
        fifo_full = (count_q == CW'(FIFO_DEPTH));
        // Readiness is judged on the pre-pop occupancy, so a full queue refuses even while draining.
        req_ready = reset && !fifo_full;
        req_hit   = req_valid && req_ready;
        push      = req_hit && (req_dest != LOCAL_ADDR);
        pop       = (state_q == SEND) && !tx_full;

        req_err_d    = req_hit && (req_dest == LOCAL_ADDR);
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        sent_count_d = sent_count_q;
        gap_d        = gap_q;

        unique case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (count_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_data_d  = mem_q[rd_ptr_q];
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (!tx_full) begin
                    tx_valid_d   = 1'b0;
                    sent_count_d = sent_count_q + 16'd1;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = 4'(GAP_CYCLES);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                tx_valid_d = 1'b0;
                if (gap_q <= 4'd1) begin
                    gap_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            req_err_q    <= 1'b0;
            sent_count_q <= 16'd0;
            gap_q        <= 4'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            req_err_q    <= req_err_d;
            sent_count_q <= sent_count_d;
            gap_q        <= gap_d;
        end
    end

    // Storage needs no reset: the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_dest, req_payload};
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign req_err    = req_err_q;
    assign sent_count = sent_count_q;
    assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_spine_port_injector.sv
// tb/tb_spine_port_injector.sv - directed bench for spine_port_injector
// dut uses a 4-cycle gap, dut_z shares its inputs and uses a zero gap.
module tb_spine_port_injector;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [5:0]  req_dest;
    logic [9:0]  req_payload;
    logic        tx_full;

    logic        req_ready, req_err, tx_valid, busy;
    logic [15:0] tx_data, sent_count;
    logic        req_ready_z, req_err_z, tx_valid_z, busy_z;
    logic [15:0] tx_data_z, sent_count_z;

    int          checks;
    int          errors;
    logic [15:0] got [16];
    int          n_got;
    int          min_low;
    int          max_low;
    bit          timed_out;

    spine_port_injector #(.DWIDTH(16), .FIFO_DEPTH(4), .GAP_CYCLES(4), .LOCAL_ADDR(6'b000000)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_dest(req_dest),
        .req_payload(req_payload), .req_ready(req_ready), .req_err(req_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_full(tx_full),
        .sent_count(sent_count), .busy(busy)
    );

    spine_port_injector #(.DWIDTH(16), .FIFO_DEPTH(4), .GAP_CYCLES(0), .LOCAL_ADDR(6'b000000)) dut_z (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_dest(req_dest),
        .req_payload(req_payload), .req_ready(req_ready_z), .req_err(req_err_z),
        .tx_data(tx_data_z), .tx_valid(tx_valid_z), .tx_full(tx_full),
        .sent_count(sent_count_z), .busy(busy_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit use_z, input int max_cycles);
        int          low_run;
        logic        v;
        logic        b;
        logic [15:0] d;
        n_got     = 0;
        low_run   = 0;
        min_low   = 1000;
        max_low   = 0;
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            v = use_z ? tx_valid_z : tx_valid;
            b = use_z ? busy_z : busy;
            d = use_z ? tx_data_z : tx_data;
            if (v) begin
                if (n_got < 16) got[n_got] = d;
                if (n_got > 0) begin
                    if (low_run < min_low) min_low = low_run;
                    if (low_run > max_low) max_low = low_run;
                end
                n_got++;
                low_run = 0;
            end else begin
                if (!b) begin
                    timed_out = 1'b0;
                    break;
                end
                low_run++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_dest = '0; req_payload = '0; tx_full = 1'b0;
        #12;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL reset_tx_data got %h want 0000", tx_data); end
        checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL reset_req_err got %b want 0", req_err); end
        checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL reset_sent_count got %0d want 0", sent_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        step();
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_single();
        req_valid = 1'b1; req_dest = 6'b010011; req_payload = 10'h155;
        step();
        req_valid = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_n got %b want 0", tx_valid); end
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_n1 got %b want 0", tx_valid); end
        step();
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", tx_valid); end
        checks++; if (tx_data !== 16'h4D55) begin errors++; $display("FAIL single_data got %h want 4d55", tx_data); end
        step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b want 0", tx_valid); end
        checks++; if (sent_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", sent_count); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy cycle %0d got %b want 1", i, busy); end
            step();
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_last got %b want 1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        tx_full = 1'b1;
        req_valid = 1'b1; req_dest = 6'h21; req_payload = 10'h2AA;
        step();
        req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== 16'h86AA || sent_count !== 16'd1) begin
                errors++; $display("FAIL bp_hold cycle %0d got v=%b d=%h c=%0d want v=1 d=86aa c=1", i, tx_valid, tx_data, sent_count);
            end
            step();
        end
        tx_full = 1'b0;
        step();
        checks++; if (tx_valid !== 1'b0 || sent_count !== 16'd2) begin
            errors++; $display("FAIL bp_release got v=%b c=%0d want v=0 c=2", tx_valid, sent_count);
        end
        for (int i = 0; i < 20 && busy; i++) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", busy); end
    endtask

    task automatic test_fill();
        logic [5:0]  dl [4];
        logic [9:0]  pl [4];
        logic [15:0] base;
        dl = '{6'h01, 6'h12, 6'h23, 6'h3E};
        pl = '{10'h3FF, 10'h000, 10'h2A5, 10'h15A};
        base = sent_count;
        tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1;
            req_dest = (k < 4) ? dl[k] : 6'h3F;
            req_payload = (k < 4) ? pl[k] : 10'h3FF;
            #1;
            checks++; if (req_ready !== (k < 4)) begin errors++; $display("FAIL fill_ready req %0d got %b want %b", k, req_ready, (k < 4)); end
            step();
        end
        req_valid = 1'b0;
        tx_full = 1'b0;
        drain(1'b0, 200);
        checks++; if (timed_out || n_got != 4) begin errors++; $display("FAIL fill_count got %0d timeout=%b want 4", n_got, timed_out); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== {dl[k], pl[k]}) begin errors++; $display("FAIL fill_order pkt %0d got %h want %h", k, got[k], {dl[k], pl[k]}); end
        end
        checks++; if (min_low < 4) begin errors++; $display("FAIL fill_gap got %0d want >=4", min_low); end
        checks++; if (sent_count !== base + 16'd4) begin errors++; $display("FAIL fill_sent got %0d want %0d", sent_count, base + 16'd4); end
    endtask

    task automatic test_reject();
        req_valid = 1'b1; req_dest = 6'b000000; req_payload = 10'h0F0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rej_ready got %b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (req_err !== 1'b1) begin errors++; $display("FAIL rej_pulse got %b want 1", req_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rej_busy got %b want 0", busy); end
        step();
        checks++; if (req_err !== 1'b0) begin errors++; $display("FAIL rej_width got %b want 0", req_err); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rej_no_tx cycle %0d got %b want 0", i, tx_valid); end
            step();
        end
    endtask

    task automatic test_push_pop_wrap();
        logic [15:0] exp [9];
        for (int k = 0; k < 9; k++) exp[k] = {6'(6'h08 + k), 10'(10'h050 + 3 * k)};
        reset = 1'b0;
        step();
        reset = 1'b1;
        tx_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_dest = exp[k][15:10]; req_payload = exp[k][9:0];
            step();
        end
        req_dest = exp[4][15:10]; req_payload = exp[4][9:0];
        tx_full = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL pp_full_ready got %b want 0", req_ready); end
        checks++; if (tx_data !== exp[0] || tx_valid !== 1'b1) begin errors++; $display("FAIL pp_head got %h want %h", tx_data, exp[0]); end
        step();
        checks++; if (req_ready !== 1'b1 || sent_count !== 16'd1) begin
            errors++; $display("FAIL pp_after_pop got r=%b c=%0d want r=1 c=1", req_ready, sent_count);
        end
        step();
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL pp_refull got %b want 0", req_ready); end
        drain(1'b0, 200);
        checks++; if (timed_out || n_got != 4) begin errors++; $display("FAIL pp_count got %0d timeout=%b want 4", n_got, timed_out); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== exp[k+1]) begin errors++; $display("FAIL pp_order pkt %0d got %h want %h", k, got[k], exp[k+1]); end
        end
        tx_full = 1'b1;
        for (int k = 5; k < 9; k++) begin
            req_valid = 1'b1; req_dest = exp[k][15:10]; req_payload = exp[k][9:0];
            step();
        end
        req_valid = 1'b0;
        tx_full = 1'b0;
        drain(1'b0, 200);
        checks++; if (timed_out || n_got != 4) begin errors++; $display("FAIL wrap_count got %0d timeout=%b want 4", n_got, timed_out); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== exp[k+5]) begin errors++; $display("FAIL wrap_order pkt %0d got %h want %h", k, got[k], exp[k+5]); end
        end
        checks++; if (sent_count !== 16'd9) begin errors++; $display("FAIL wrap_sent got %0d want 9", sent_count); end
    endtask

    task automatic test_reset_mid_send();
        int          highs;
        logic [15:0] exp [3];
        exp = '{16'hA001, 16'h5C3E, 16'hFFFF};
        tx_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_dest = 6'(k + 5); req_payload = 10'(k * 7 + 1);
            step();
        end
        req_valid = 1'b0;
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %b want 1", tx_valid); end
        reset = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || sent_count !== 16'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_async got v=%b c=%0d b=%b want v=0 c=0 b=0", tx_valid, sent_count, busy);
        end
        step();
        step();
        reset = 1'b1;
        tx_full = 1'b0;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) highs++;
            step();
        end
        checks++; if (highs != 0 || sent_count !== 16'd0) begin
            errors++; $display("FAIL mid_stale got highs=%0d c=%0d want 0 and 0", highs, sent_count);
        end
        tx_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_dest = exp[k][15:10]; req_payload = exp[k][9:0];
            #1;
            checks++; if (req_ready_z !== 1'b1) begin errors++; $display("FAIL g0_ready req %0d got %b want 1", k, req_ready_z); end
            step();
        end
        req_valid = 1'b0;
        tx_full = 1'b0;
        drain(1'b1, 100);
        checks++; if (timed_out || n_got != 3) begin errors++; $display("FAIL g0_count got %0d timeout=%b want 3", n_got, timed_out); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL g0_order pkt %0d got %h want %h", k, got[k], exp[k]); end
        end
        checks++; if (min_low != 2 || max_low != 2) begin
            errors++; $display("FAIL g0_spacing got low %0d..%0d want 2..2", min_low, max_low);
        end
        checks++; if (sent_count_z !== 16'd3) begin errors++; $display("FAIL g0_sent got %0d want 3", sent_count_z); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_fill();
        test_reject();
        test_push_pop_wrap();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
